// File: rtl/fetch_buffer.sv
// fetch_buffer: prefetch queue between the instruction-bus response channel
// and the FE/ID pipeline register. It tracks in-flight requests, discards
// stale responses after a flush and throttles the fetch unit so responses can
// always be absorbed.
// Optional feature macro: FETCH_BUF_PARITY_EN (per-entry even parity, fault
// reported in info[3]).
module fetch_buffer #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          s_clk_i,
    input  logic          s_resetn_i,
    input  logic          s_flush_i,
    input  logic          s_stall_i,
    input  logic          s_req_i,
    output logic          s_req_ok_o,
    input  logic          s_push_i,
    input  logic [31:0]   s_data_i,
    input  logic          s_berr_i,
    input  logic [1:0]    s_pred_i,
    output logic [31:0]   s_feid_instr_o,
    output logic [4:0]    s_feid_info_o,
    output logic [1:0]    s_feid_pred_o,
    output logic [CW-1:0] s_count_o
);

    localparam int AW = $clog2(DEPTH);
    // Outstanding and discard counters need one extra bit: after a flush the
    // discard count can reach DEPTH while DEPTH new requests are in flight.
    localparam int OW = CW + 1;
`ifdef FETCH_BUF_PARITY_EN
    localparam int EW = 36;
`else
    localparam int EW = 35;
`endif

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] disc_q, disc_d;
    logic          first_q, first_d;
    logic [31:0]   instr_q, instr_d;
    logic [4:0]    info_q, info_d;
    logic [1:0]    pred_q, pred_d;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;
    logic          parity_fault;

    logic          live_push;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          fifo_we;
    logic          load_bypass;
    logic [OW-1:0] budget_used;

    // Entry packing {[parity,] data, berr, pred}; parity makes the whole entry even
    always_comb begin
        rd_entry = mem_q[rd_ptr_q];
`ifdef FETCH_BUF_PARITY_EN
        wr_entry     = {^{s_data_i, s_berr_i, s_pred_i}, s_data_i, s_berr_i, s_pred_i};
        parity_fault = ^rd_entry;
`else
        wr_entry     = {s_data_i, s_berr_i, s_pred_i};
        parity_fault = 1'b0;
`endif
    end

    // Classify this cycle's push and decide between pop, bypass and enqueue
    always_comb begin
        live_push   = s_push_i && (disc_q == '0) && !s_flush_i;
        fifo_empty  = (count_q == '0);
        fifo_pop    = !s_flush_i && !s_stall_i && !fifo_empty;
        load_bypass = !s_flush_i && !s_stall_i && fifo_empty && live_push;
        fifo_we     = live_push && !load_bypass;
        budget_used = (outst_q - disc_q) + OW'(count_q);
        s_req_ok_o  = budget_used < OW'(DEPTH);
    end

    // Next-state for pointers, occupancy, outstanding and discard counters
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        outst_d  = outst_q + OW'(s_req_i) - OW'(s_push_i);
        disc_d   = disc_q;
        if (s_flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            disc_d   = outst_q - OW'(s_push_i);
        end else begin
            if (s_push_i && (disc_q != '0)) begin
                disc_d = disc_q - OW'(1);
            end
            if (fifo_we) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (fifo_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(fifo_we) - CW'(fifo_pop);
        end
    end

    // Next-state for the FE/ID output register and the first-after-flush flag
    always_comb begin
        instr_d = instr_q;
        info_d  = info_q;
        pred_d  = pred_q;
        first_d = first_q;
        if (s_flush_i) begin
            info_d  = '0;
            first_d = 1'b1;
        end else if (!s_stall_i) begin
            if (fifo_pop) begin
                instr_d = rd_entry[34:3];
                pred_d  = rd_entry[1:0];
                info_d  = {1'b0, parity_fault, first_q, rd_entry[2], 1'b1};
                first_d = 1'b0;
            end else if (load_bypass) begin
                instr_d = s_data_i;
                pred_d  = s_pred_i;
                info_d  = {1'b0, 1'b0, first_q, s_berr_i, 1'b1};
                first_d = 1'b0;
            end else begin
                info_d = '0;
            end
        end
    end

    // Control and output registers with asynchronous active-low reset
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            outst_q  <= '0;
            disc_q   <= '0;
            first_q  <= 1'b1;
            instr_q  <= '0;
            info_q   <= '0;
            pred_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            disc_q   <= disc_d;
            first_q  <= first_d;
            instr_q  <= instr_d;
            info_q   <= info_d;
            pred_q   <= pred_d;
        end
    end

    // Storage array; contents need no reset since occupancy guards every read
    always_ff @(posedge s_clk_i) begin
        if (fifo_we) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign s_feid_instr_o = instr_q;
    assign s_feid_info_o  = info_q;
    assign s_feid_pred_o  = pred_q;
    assign s_count_o      = count_q;

    // The fetch unit must only issue when it has been granted room
    a_req_protocol: assert property (@(posedge s_clk_i) disable iff (!s_resetn_i)
        !(s_req_i && !s_req_ok_o));

    // With the grant honoured a write can never land in a full FIFO
    a_no_overflow: assert property (@(posedge s_clk_i) disable iff (!s_resetn_i)
        !(fifo_we && !fifo_pop && (count_q == CW'(DEPTH))));

endmodule
